// File: rtl/memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memory: 1 KiB word-organised data RAM, byte-addressed, full-word writes, |
// |         word and byte read ports. Optional MEMORY_REGISTERED_READ_EN     |
// |         adds a one-cycle registered, read-first read path.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module memory #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readword,
  output logic [7:0]        readbyte
);

  localparam int c_depth = 2 ** (ADDR_W - 2);

  logic [DATA_W-1:0] r_mem [c_depth];
  logic [ADDR_W-3:0] w_index;
  logic [1:0]        w_lane;
  logic [DATA_W-1:0] w_word;
  logic [7:0]        w_byte;

  assign w_index = address[ADDR_W-1:2];
  assign w_lane  = address[1:0];
  assign w_word  = r_mem[w_index];
  assign w_byte  = w_word[{w_lane, 3'b000} +: 8];

  // Lane bits are ignored on write: a misaligned address updates the containing word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write) begin
      r_mem[w_index] <= writedata;
    end
  end

`ifdef MEMORY_REGISTERED_READ_EN
  logic [DATA_W-1:0] r_readword;
  logic [7:0]        r_readbyte;

  // Sampled from the pre-write array, so a same-edge write is seen one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_readword <= '0;
      r_readbyte <= '0;
    end else begin
      r_readword <= w_word;
      r_readbyte <= w_byte;
    end
  end

  assign readword = r_readword;
  assign readbyte = r_readbyte;
`else
  assign readword = w_word;
  assign readbyte = w_byte;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memory: self-checking bench for memory, directed steps followed by    |
// |            random traffic against an array reference model.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_memory;

`ifdef MEMORY_REGISTERED_READ_EN
  localparam bit c_regread = 1'b1;
`else
  localparam bit c_regread = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [9:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readword;
  logic [7:0]  readbyte;

  logic [31:0] model [256];
  int n_cmp;
  int n_fail;

  memory #(.ADDR_W(10), .DATA_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .write    (write),
    .writedata(writedata),
    .readword (readword),
    .readbyte (readbyte)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] lane_of(input logic [31:0] w, input logic [1:0] lane);
    return 8'((w >> (8 * int'(lane))) & 32'hFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, model the edge, check #1 after it.
  task automatic step(input string tag, input logic [9:0] a, input logic wr, input logic [31:0] d);
    logic [31:0] pre;
    logic [31:0] exp;
    @(negedge clock);
    address   = a;
    write     = wr;
    writedata = d;
    pre = model[a[9:2]];
    @(posedge clock);
    if (wr) model[a[9:2]] = d;
    #1;
    exp = c_regread ? pre : model[a[9:2]];
    chk({tag, ".word"}, readword, exp);
    chk({tag, ".byte"}, {24'h0, readbyte}, {24'h0, lane_of(exp, a[1:0])});
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    clear_model();
    reset = 1'b1;
    address = 10'd0;
    write = 1'b0;
    writedata = 32'h0;
    #2;
    chk("reset.word", readword, 32'h0);
    chk("reset.byte", {24'h0, readbyte}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Reset clears previously written data
    step("wr8", 10'd8, 1'b1, 32'hFFFF_FFFF);
    step("rd8", 10'd8, 1'b0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    clear_model();
    #1;
    chk("rst8.word", readword, 32'h0);
    chk("rst8.byte", {24'h0, readbyte}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    step("rd8post", 10'd8, 1'b0, 32'h0);
    step("rd8post2", 10'd8, 1'b0, 32'h0);

    // Basic write, lane reads, second word
    step("wr0", 10'd0, 1'b1, 32'h0BAD_F00D);
    step("rd0", 10'd0, 1'b0, 32'h0);
    step("rd1", 10'd1, 1'b0, 32'h0);
    step("rd2", 10'd2, 1'b0, 32'h0);
    step("rd3", 10'd3, 1'b0, 32'h0);
    step("wr4", 10'd4, 1'b1, 32'hABC5_6F33);
    step("rd4", 10'd4, 1'b0, 32'h0);
    step("rd0b", 10'd0, 1'b0, 32'h0);

    // Misaligned write, then write disabled with changing data
    step("wr6", 10'd6, 1'b1, 32'h1234_5678);
    step("rd6", 10'd6, 1'b0, 32'hDEAD_BEEF);
    step("rd4b", 10'd4, 1'b0, 32'hCAFE_F00D);
    step("rd5", 10'd5, 1'b0, 32'h0);

    // Back-to-back writes to one word: last wins
    step("bb1", 10'd12, 1'b1, 32'h1111_1111);
    step("bb2", 10'd13, 1'b1, 32'h2222_2222);
    step("bb3", 10'd15, 1'b0, 32'h0);

    // Reset asserted mid-cycle during a write to word 0
    @(negedge clock);
    address = 10'd0;
    write = 1'b1;
    writedata = 32'h5555_AAAA;
    #2;
    reset = 1'b1;
    clear_model();
    #1;
    chk("rstcol.word", readword, 32'h0);
    chk("rstcol.byte", {24'h0, readbyte}, 32'h0);
    @(posedge clock);
    #1;
    chk("rstcol.hold", readword, 32'h0);
    @(negedge clock);
    write = 1'b0;
    reset = 1'b0;
    step("rstcol.rd0", 10'd0, 1'b0, 32'h0);
    step("rstcol.rd4", 10'd4, 1'b0, 32'h0);

    // Random traffic, biased to a few words so reads hit written data
    for (int i = 0; i < 400; i++) begin
      logic [9:0] a;
      a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : {3'b000, 7'($urandom_range(0, 31))};
      step("rand", a, 1'($urandom_range(0, 1)), $urandom);
    end

    // Sweep all words to confirm no stray corruption
    for (int i = 0; i < 256; i++) begin
      step("sweep", {8'(i), 2'($urandom_range(0, 3))}, 1'b0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory.md
Name: memory

Overview:
- Word-organised 1 KiB data RAM: 256 words × 32 bit, byte-addressed through a 10-bit address.
- Synchronous full-word write and combinational read.
- Provides both the addressed 32-bit word and the addressed byte.
- Serves as the data/instruction store of the RISC-V computer; sits directly on the CPU load/store path.

Parameters:
- ADDR_W, 10, byte-address width; depth = 2**(ADDR_W-2) words.
- DATA_W, 32, word width; fixed at 32 (byte lanes assume 4 bytes/word).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears entire array.
- address  input  ADDR_W  byte address; [ADDR_W-1:2] = word index, [1:0] = byte lane.
- write  input  1  write enable, sampled on rising clock edge.
- writedata  input  32  word to store.
- readword  output  32  word at address[ADDR_W-1:2].
- readbyte  output  8  byte at address[1:0] within that word.

Behaviour:
- Storage: array of 256 × 32-bit registers, word index w = address[9:2].
- Reset:
  - reset high clears every word to 32'h0000_0000 immediately, without waiting for a clock edge.
  - While reset is held, readword = 0 and readbyte = 0.
  - Reset takes priority over a simultaneous write; the write is discarded.
- Write:
  - On a rising clock edge with write=1 and reset=0, mem[w] <= writedata (full word).
  - address[1:0] is ignored for writes; misaligned addresses write the containing word.
  - No byte or halfword writes.
- Read (default build):
  - Purely combinational: readword = mem[w].
  - readbyte = mem[w][8*address[1:0] +: 8], little-endian: lane 0 = bits 7:0 … lane 3 = bits 31:24.
  - Read-after-write: new data is visible on readword/readbyte right after the write edge, within the same cycle the updated register settles. No bypass is needed beyond that.
- Changing address alone never alters contents.
- write=0 holds all contents indefinitely.
- Back-to-back writes on consecutive edges: each edge writes independently.
- Same word written twice: the last write wins.
- Out-of-range addresses are impossible; the full 10-bit space maps to the array.
- Outputs never X after the first reset.

Optional Feature:
- Macro MEMORY_REGISTERED_READ_EN.
- Defined:
  - readword and readbyte are registered on the rising clock edge from the current address/array: one-cycle read latency.
  - Registered outputs clear to 0 asynchronously on reset.
  - A write and a read of the same word on the same edge returns the old data (read-first); the new data appears the following cycle.
- Undefined: combinational read as above, zero latency.
- All other behaviour is identical in both builds.

Test Plan:
- Reset clear: write 32'hFFFF_FFFF to address 8, pulse reset high for 1 cycle -> readword at address 8 = 0, readbyte = 0.
- Basic write/read: address=0, writedata=32'h0BADF00D, write=1 for one edge -> readword = 32'h0BADF00D, readbyte = 8'h0D.
- Byte lanes: address 1/2/3 with word 0 holding 32'h0BADF00D -> readword unchanged; readbyte = 8'hF0 / 8'hAD / 8'h0B.
- Second word, no aliasing: address=4, writedata=32'hABC56F33, write pulse -> readword = 32'hABC56F33, readbyte = 8'h33; address=0 still reads 32'h0BADF00D.
- Misaligned write and write-disable:
  - address=6, writedata=32'h12345678, write pulse -> word 1 = 32'h12345678, readbyte at address 6 = 8'h34.
  - Then writedata changed with write=0 -> contents unchanged.
- Reset vs. write collision: reset asserted asynchronously mid-cycle while write=1 at address 0 -> word 0 = 0 after reset release; under MEMORY_REGISTERED_READ_EN, read data lags address by exactly one edge.
